seg_scan_display: RTL
=====================

SEG_SCAN_DISPLAY -- requirements
Module: seg_scan_display

Interface
REQ-001 The block SHALL have parameter NUM_DIGITS, default 4: number of multiplexed digits (1..8).
REQ-002 The block SHALL have parameter DWELL, default 1: clock cycles each digit is driven (>=1).
REQ-003 The block SHALL have parameter BLINK_HALF, default 250: cycles per blink half-period (0.5 s at 500 Hz, >=1).
REQ-004 The block SHALL have port clk_500Hz, input, 1 bit: scan clock, rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port values, input, 4*NUM_DIGITS bits: BCD nibbles, digit i at [4i+3:4i].
REQ-007 The block SHALL have port blank_mask, input, NUM_DIGITS bits: bit i=1 blanks digit i.
REQ-008 The block SHALL have port full, input, 1 bit: lot full, requests blinking.
REQ-009 The block SHALL have port SEG_SEL, output, NUM_DIGITS bits: one-hot digit enable, active-high.
REQ-010 The block SHALL have port SEG_DATA, output, 8 bits: segment pattern, bit7 dp, bits6:0 g..a, active-high.
REQ-011 The block SHALL have port frame_start, output, 1 bit: high for the first cycle of each digit-0 slot.

Function
REQ-012 The block SHALL keep digit index idx (0..NUM_DIGITS-1) and dwell counter dcnt (0..DWELL-1).
REQ-013 The block SHALL increment dcnt each edge; at DWELL-1, dcnt SHALL wrap to 0 and idx SHALL advance, wrapping NUM_DIGITS-1 to 0.
REQ-014 On each edge starting a frame (idx becomes 0, dcnt becomes 0), the block SHALL snapshot values, blank_mask and full.
REQ-015 The block SHALL use the snapshot for every digit of that frame; input changes mid-frame SHALL NOT affect that frame.
REQ-016 SEG_SEL, SEG_DATA and frame_start SHALL be registered from next-state values, so they always match the current idx; digit 0 SHALL show inputs sampled at the same edge.
REQ-017 Decode: 0..9 SHALL give 3F,06,5B,4F,66,6D,7D,07,7F,6F hex; 10..15 SHALL give 40 (dash); dp SHALL be 0.
REQ-018 A blanked digit SHALL drive SEG_SEL=0 and SEG_DATA=00 for its whole slot; idx SHALL still advance.
REQ-019 With NUM_DIGITS=1, SEG_SEL SHALL be constantly 1 outside reset and blink-off; frame_start SHALL pulse every DWELL cycles.

Reset
REQ-020 While reset=0, SEG_SEL, SEG_DATA, frame_start, snapshot and blink counter SHALL be 0, blink phase SHALL be on, idx=NUM_DIGITS-1 and dcnt=DWELL-1.
REQ-021 The first edge after reset release SHALL start a frame at digit 0.
REQ-022 Asserting reset mid-frame SHALL clear outputs immediately, without waiting for a clock edge.

Configuration
REQ-023 With SEG_BLINK_EN defined, a free-running counter SHALL toggle the blink phase every BLINK_HALF cycles.
REQ-024 With SEG_BLINK_EN defined, snapshot full=1 and phase off SHALL force SEG_SEL=0 and SEG_DATA=00; idx and frame_start SHALL be unaffected.
REQ-025 Without SEG_BLINK_EN, full SHALL be ignored and no blink counter SHALL be synthesised.

Structure
REQ-026 Package seg_disp_pkg SHALL hold the digit codes SEG_0..SEG_9, SEG_DASH (40h) and SEG_OFF (00h).
REQ-027 Sub-module seg7_decode SHALL be combinational, mapping a 4-bit nibble to an 8-bit pattern; it SHALL be instantiated once.

Verification (NUM_DIGITS=4, DWELL=1, BLINK_HALF=4 unless stated)
REQ-028 values=4321h, mask=0, reset release -> SEG_SEL 0001,0010,0100,1000 repeating; SEG_DATA 06,5B,4F,66; frame_start with 0001.
REQ-029 values changes 4321h->0000h while idx=2 -> rest of frame shows 4F,66; next frame shows 3F x4.
REQ-030 values=00A5h, mask=1100b -> digit0=6D, digit1=40, slots 2-3 SEG_SEL=0000 and SEG_DATA=00.
REQ-031 SEG_BLINK_EN defined, full=1 -> outputs alternate 4 cycles driven, 4 cycles all-zero; full=0 -> continuous scan from next frame.
REQ-032 DWELL=3 -> each SEG_SEL value held 3 cycles; frame_start high 1 of every 12 cycles.
REQ-033 reset pulsed low while idx=2 -> outputs 0 asynchronously; on release, the next edge shows digit 0.

Source files
------------

// File: rtl/seg_disp_pkg.sv
// Purpose: shared seven-segment codes for the scanned display (bit7 dp, bits6:0 g..a, active-high).
// Latency: n/a (constants only).
// Backpressure: n/a.
package seg_disp_pkg;

  localparam logic [7:0] SEG_0    = 8'h3F;
  localparam logic [7:0] SEG_1    = 8'h06;
  localparam logic [7:0] SEG_2    = 8'h5B;
  localparam logic [7:0] SEG_3    = 8'h4F;
  localparam logic [7:0] SEG_4    = 8'h66;
  localparam logic [7:0] SEG_5    = 8'h6D;
  localparam logic [7:0] SEG_6    = 8'h7D;
  localparam logic [7:0] SEG_7    = 8'h07;
  localparam logic [7:0] SEG_8    = 8'h7F;
  localparam logic [7:0] SEG_9    = 8'h6F;
  // Non-BCD nibbles show a centre bar so a bad value is visible rather than silent.
  localparam logic [7:0] SEG_DASH = 8'h40;
  localparam logic [7:0] SEG_OFF  = 8'h00;

endpackage : seg_disp_pkg

// File: rtl/seg7_decode.sv
// Purpose: BCD nibble to seven-segment pattern, decimal point always off.
// Latency: combinational, zero cycles.
// Backpressure: none.
module seg7_decode
  import seg_disp_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [7:0] seg_o
);

  // Table lookup; 10..15 fall through to the dash pattern.
  always_comb begin
    seg_o = SEG_DASH;
    case (nibble_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule : seg7_decode

// File: rtl/seg_scan_display.sv
// Purpose: multiplexed seven-segment scanner; frame-coherent snapshot of values/mask/full; optional blink (SEG_BLINK_EN).
// Latency: outputs registered from next-state, so digit 0 reflects inputs sampled on the same edge that starts its frame.
// Backpressure: none; free-running scan, inputs are sampled once per frame.
module seg_scan_display
  import seg_disp_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int DWELL      = 1,
  parameter int BLINK_HALF = 250
) (
  input  logic                      clk_500Hz,
  input  logic                      reset,
  input  logic [4*NUM_DIGITS-1:0]   values,
  input  logic [NUM_DIGITS-1:0]     blank_mask,
  input  logic                      full,
  output logic [NUM_DIGITS-1:0]     SEG_SEL,
  output logic [7:0]                SEG_DATA,
  output logic                      frame_start
);

  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DCNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DWELL - 1);

  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [DCNT_W-1:0]         dcnt_q, dcnt_d;
  logic [4*NUM_DIGITS-1:0]   snap_vals_q, snap_vals_d;
  logic [NUM_DIGITS-1:0]     snap_mask_q, snap_mask_d;
  logic                      snap_full_q, snap_full_d;
  logic [NUM_DIGITS-1:0]     sel_q, sel_d;
  logic [7:0]                data_q, data_d;
  logic                      frame_start_q, frame_start_d;

  logic                      dwell_wrap;
  logic [3:0]                nibble;
  logic                      digit_blank;
  logic [NUM_DIGITS-1:0]     onehot;
  logic [7:0]                seg_pat;
  logic                      blink_off;

  // Scan position: dwell counter rolls first, digit index advances on its wrap.
  always_comb begin
    dwell_wrap    = (dcnt_q == DCNT_LAST);
    dcnt_d        = dwell_wrap ? '0 : dcnt_q + 1'b1;
    idx_d         = idx_q;
    if (dwell_wrap) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
    frame_start_d = dwell_wrap && (idx_q == IDX_LAST);
  end

  // Snapshot is taken as the frame begins so digit 0 already sees the new inputs.
  always_comb begin
    snap_vals_d = frame_start_d ? values     : snap_vals_q;
    snap_mask_d = frame_start_d ? blank_mask : snap_mask_q;
    snap_full_d = frame_start_d ? full       : snap_full_q;
  end

  // Select the nibble, blank bit and enable line for the upcoming digit.
  always_comb begin
    nibble      = 4'd0;
    digit_blank = 1'b0;
    onehot      = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_d == IDX_W'(i)) begin
        nibble      = snap_vals_d[4*i +: 4];
        digit_blank = snap_mask_d[i];
        onehot[i]   = 1'b1;
      end
    end
  end

  seg7_decode u_decode (
    .nibble_i (nibble),
    .seg_o    (seg_pat)
  );

`ifdef SEG_BLINK_EN
  localparam int BCNT_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(BLINK_HALF - 1);

  logic [BCNT_W-1:0] bcnt_q, bcnt_d;
  logic              phase_on_q, phase_on_d;

  // Free-running half-period counter; phase flips each time it wraps.
  always_comb begin
    bcnt_d     = (bcnt_q == BCNT_LAST) ? '0 : bcnt_q + 1'b1;
    phase_on_d = (bcnt_q == BCNT_LAST) ? ~phase_on_q : phase_on_q;
    blink_off  = snap_full_d && !phase_on_d;
  end

  // Blink state starts in the lit phase after reset.
  always_ff @(posedge clk_500Hz or negedge reset) begin
    if (!reset) begin
      bcnt_q     <= '0;
      phase_on_q <= 1'b1;
    end else begin
      bcnt_q     <= bcnt_d;
      phase_on_q <= phase_on_d;
    end
  end
`else
  // Without blinking the full flag has no effect; keep it visibly consumed.
  logic full_unused;
  logic snap_full_unused;
  assign full_unused      = full;
  assign snap_full_unused = snap_full_d;
  assign blink_off        = 1'b0;
`endif

  // Blanked digits and the blink-off phase both dark the slot but keep scanning.
  always_comb begin
    sel_d  = onehot;
    data_d = seg_pat;
    if (digit_blank || blink_off) begin
      sel_d  = '0;
      data_d = SEG_OFF;
    end
  end

  // State and output registers; reset parks the scan on the last slot so the first edge starts a frame.
  always_ff @(posedge clk_500Hz or negedge reset) begin
    if (!reset) begin
      idx_q         <= IDX_LAST;
      dcnt_q        <= DCNT_LAST;
      snap_vals_q   <= '0;
      snap_mask_q   <= '0;
      snap_full_q   <= 1'b0;
      sel_q         <= '0;
      data_q        <= SEG_OFF;
      frame_start_q <= 1'b0;
    end else begin
      idx_q         <= idx_d;
      dcnt_q        <= dcnt_d;
      snap_vals_q   <= snap_vals_d;
      snap_mask_q   <= snap_mask_d;
      snap_full_q   <= snap_full_d;
      sel_q         <= sel_d;
      data_q        <= data_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign SEG_SEL     = sel_q;
  assign SEG_DATA    = data_q;
  assign frame_start = frame_start_q;

endmodule : seg_scan_display
